// File: rtl/demux_1to2_stream_if.sv
// demux_1to2_stream_if
//   Stream bundle for the 1-to-2 demultiplexer: one input stream plus two
//   output channels, each with its own valid/ready handshake.
//   Modports:
//     slave  - the demultiplexer's view (consumes in_*, produces out*_*)
//     master - the environment's view (drives in_*, consumes out*_*)
//   Signals:
//     in_data/in_sel/in_valid -> in_ready
//     out0_data/out0_valid    <- out0_ready
//     out1_data/out1_valid    <- out1_ready
interface demux_1to2_stream_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;

    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid
    );

    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid
    );
endinterface

// File: rtl/demux_1to2_stream.sv
// demux_1to2_stream
//   Registered 1-to-2 stream demultiplexer. Each input beat is steered to
//   channel 0 or 1 by in_sel and held in that channel's output register until
//   its consumer takes it. A stalled channel never blocks the other.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - demux_1to2_stream_if.slave (input stream + two output channels)
//     cnt0/1 - accepted-beat counters per channel (only with DEMUX_CNT_EN)
//   Optional feature macro: DEMUX_CNT_EN (adds cnt0/cnt1, modulo 2^CNT_W).
//
//   Per-channel state:
//     state    | meaning
//     ST_EMPTY | output register holds no beat, outN_valid = 0
//     ST_FULL  | output register holds a beat,   outN_valid = 1
module demux_1to2_stream #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    demux_1to2_stream_if.slave     bus
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0]       cnt0,
    output logic [CNT_W-1:0]       cnt1
`endif
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       r_state0, r_state1;
    logic [0:0]       w_state0_nxt, w_state1_nxt;
    logic [WIDTH-1:0] r_data0, r_data1;
    logic             w_ready;
    logic             w_load0, w_load1;
    logic             w_drain0, w_drain1;

    // Readiness only looks at the addressed channel, so a full and stalled
    // channel cannot hold off beats for the other one.
    assign w_ready  = bus.in_sel ? ((r_state1 == ST_EMPTY) | bus.out1_ready)
                                 : ((r_state0 == ST_EMPTY) | bus.out0_ready);
    assign w_load0  = bus.in_valid & w_ready & ~bus.in_sel;
    assign w_load1  = bus.in_valid & w_ready &  bus.in_sel;
    assign w_drain0 = (r_state0 == ST_FULL) & bus.out0_ready;
    assign w_drain1 = (r_state1 == ST_FULL) & bus.out1_ready;

    always_comb begin
        w_state0_nxt = r_state0;
        case (r_state0)
            ST_EMPTY: if (w_load0)              w_state0_nxt = ST_FULL;
            ST_FULL:  if (w_drain0 && !w_load0) w_state0_nxt = ST_EMPTY;
            default:                            w_state0_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        w_state1_nxt = r_state1;
        case (r_state1)
            ST_EMPTY: if (w_load1)              w_state1_nxt = ST_FULL;
            ST_FULL:  if (w_drain1 && !w_load1) w_state1_nxt = ST_EMPTY;
            default:                            w_state1_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state0 <= ST_EMPTY;
            r_state1 <= ST_EMPTY;
            r_data0  <= '0;
            r_data1  <= '0;
        end else begin
            r_state0 <= w_state0_nxt;
            r_state1 <= w_state1_nxt;
            // Data is only written on a load, so it persists after a drain.
            if (w_load0) r_data0 <= bus.in_data;
            if (w_load1) r_data1 <= bus.in_data;
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.out0_data  = r_data0;
    assign bus.out0_valid = (r_state0 == ST_FULL);
    assign bus.out1_data  = r_data1;
    assign bus.out1_valid = (r_state1 == ST_FULL);

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt0, r_cnt1;

    // Free-running wrap; no saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_load0) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_load1) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_demux_1to2_stream.sv
// tb_demux_1to2_stream
//   Directed bench for demux_1to2_stream with hand-computed expectations.
//   Build with +define+DEMUX_CNT_EN to include the counter checks.
module tb_demux_1to2_stream;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    demux_1to2_stream_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt0, cnt1;
`endif

    demux_1to2_stream #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0  (cnt0),
        .cnt1  (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n          = 1'b0;
        bus.in_data    = '0;
        bus.in_sel     = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;

        // Reset state and release
        step();
        chk("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
        chk("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
        chk("rst_out0_data",  32'(bus.out0_data),  32'd0);
        chk("rst_out1_data",  32'(bus.out1_data),  32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Beat 1101 to channel 0
        bus.in_data = 4'b1101; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("t2_out0_valid", 32'(bus.out0_valid), 32'd1);
        chk("t2_out0_data",  32'(bus.out0_data),  32'hD);
        chk("t2_out1_valid", 32'(bus.out1_valid), 32'd0);
        step();
        chk("t2_drained",    32'(bus.out0_valid), 32'd0);
        chk("t2_data_kept",  32'(bus.out0_data),  32'hD);

        // Beat 0010 to channel 1
        bus.in_data = 4'b0010; bus.in_sel = 1'b1; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("t3_out1_valid", 32'(bus.out1_valid), 32'd1);
        chk("t3_out1_data",  32'(bus.out1_data),  32'h2);
        chk("t3_out0_data",  32'(bus.out0_data),  32'hD);
        step();
        chk("t3_drained",    32'(bus.out1_valid), 32'd0);

        // Channel 0 stalled: 1010 held, 0101 back-pressured
        bus.out0_ready = 1'b0;
        bus.in_data = 4'b1010; bus.in_sel = 1'b0; bus.in_valid = 1'b1;
        #1;
        chk("t4_ready_empty", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_data = 4'b0101;
        #1;
        chk("t4_ready_stall", 32'(bus.in_ready), 32'd0);
        step();
        chk("t4_hold_data",   32'(bus.out0_data),  32'hA);
        chk("t4_hold_valid",  32'(bus.out0_valid), 32'd1);
        bus.out0_ready = 1'b1;
        #1;
        chk("t4_ready_raise", 32'(bus.in_ready), 32'd1);
        step();
        chk("t4_next_data",   32'(bus.out0_data),  32'h5);
        chk("t4_next_valid",  32'(bus.out0_valid), 32'd1);
        bus.in_valid = 1'b0; bus.out0_ready = 1'b0;
        step();
        chk("t4_still_full",  32'(bus.out0_valid), 32'd1);

        // Channel 0 full and stalled, beat 0110 to channel 1 gets through
        bus.in_data = 4'b0110; bus.in_sel = 1'b1; bus.in_valid = 1'b1;
        #1;
        chk("t5_ready_ch1",   32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("t5_out1_data",   32'(bus.out1_data),  32'h6);
        chk("t5_out1_valid",  32'(bus.out1_valid), 32'd1);
        chk("t5_out0_data",   32'(bus.out0_data),  32'h5);
        chk("t5_out0_valid",  32'(bus.out0_valid), 32'd1);
        bus.in_sel = 1'b0;
        #1;
        chk("t5_ready_no_valid", 32'(bus.in_ready), 32'd0);
        bus.out0_ready = 1'b1;
        step();
        chk("t5_out0_drained", 32'(bus.out0_valid), 32'd0);
        chk("t5_out0_kept",    32'(bus.out0_data),  32'h5);

        // Back-to-back beats to channel 1 (load+drain each cycle)
        bus.in_sel = 1'b1; bus.in_valid = 1'b1;
        bus.in_data = 4'h9;
        step();
        chk("tp_beat0", 32'(bus.out1_data), 32'h9);
        bus.in_data = 4'hC;
        step();
        chk("tp_beat1",  32'(bus.out1_data),  32'hC);
        chk("tp_valid1", 32'(bus.out1_valid), 32'd1);
        bus.in_data = 4'h3;
        step();
        chk("tp_beat2",  32'(bus.out1_data),  32'h3);
        bus.in_valid = 1'b0;
        step();
        chk("tp_empty",  32'(bus.out1_valid), 32'd0);
        chk("tp_iso0",   32'(bus.out0_valid), 32'd0);

        // Hold a beat on channel 1, then reset mid-cycle
        bus.out1_ready = 1'b0;
        bus.in_data = 4'h7; bus.in_sel = 1'b1; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("pre_rst_valid", 32'(bus.out1_valid), 32'd1);
`ifdef DEMUX_CNT_EN
        chk("pre_rst_cnt0", 32'(cnt0), 32'd3);
        chk("pre_rst_cnt1", 32'(cnt1), 32'd6);
`endif
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out1_valid", 32'(bus.out1_valid), 32'd0);
        chk("arst_out1_data",  32'(bus.out1_data),  32'd0);
        chk("arst_out0_data",  32'(bus.out0_data),  32'd0);
`ifdef DEMUX_CNT_EN
        chk("arst_cnt0", 32'(cnt0), 32'd0);
        chk("arst_cnt1", 32'(cnt1), 32'd0);
`endif
        step();
        rst_n = 1'b1;
        bus.out1_ready = 1'b1;
        #1;
        chk("arel_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("arel_out1_valid", 32'(bus.out1_valid), 32'd0);

`ifdef DEMUX_CNT_EN
        // 257 beats to channel 1: counter wraps 255 -> 0 -> 1
        bus.in_sel = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 257; i++) begin
            bus.in_data = 4'(i);
            step();
        end
        chk("cnt_ld_dr_valid", 32'(bus.out1_valid), 32'd1);
        chk("cnt_ld_dr_data",  32'(bus.out1_data),  32'(4'(256)));
        bus.in_valid = 1'b0;
        step();
        chk("cnt_wrap_cnt1", 32'(cnt1), 32'd1);
        chk("cnt_wrap_cnt0", 32'(cnt0), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
